// File: rtl/alu_control_mc_if.sv
// alu_control_mc_if: decode request/response bundle between control unit and ALU/MDU sequencer.
interface alu_control_mc_if #(parameter int OP_W = 5);
  logic            flush_i;
  logic            valid_i;
  logic            is_immediate_i;
  logic [1:0]      ALU_CO_i;
  logic [6:0]      FUNC7_i;
  logic [2:0]      FUNC3_i;
  logic [OP_W-1:0] ALU_OP_o;
  logic            op_valid_o;
  logic            is_mdu_o;
  logic            mdu_start_o;
  logic            stall_o;
  logic            done_o;
  modport master (
    output flush_i, valid_i, is_immediate_i, ALU_CO_i, FUNC7_i, FUNC3_i,
    input  ALU_OP_o, op_valid_o, is_mdu_o, mdu_start_o, stall_o, done_o
  );
  modport slave (
    input  flush_i, valid_i, is_immediate_i, ALU_CO_i, FUNC7_i, FUNC3_i,
    output ALU_OP_o, op_valid_o, is_mdu_o, mdu_start_o, stall_o, done_o
  );
endinterface

// File: rtl/alu_control_mc.sv
// alu_control_mc: registered ALU/MDU opcode decoder with multi-cycle MDU stall sequencer.
// RV_M_EXT_EN enables RV32M decode and the MUL/DIV wait FSM; undefined ties MDU outputs low.
module alu_control_mc #(
  parameter int OP_W       = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input logic            clk_i,
  input logic            rst_n_i,
  alu_control_mc_if.slave bus
);
  logic [3:0]      base_op;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic            op_valid_q, op_valid_d;
  logic            accept;
  always_comb begin
    base_op = 4'b0000;
    case (bus.ALU_CO_i)
      2'b00: base_op = 4'b0010;
      2'b01:
        case (bus.FUNC3_i)
          3'b001:  base_op = 4'b0011;
          3'b100:  base_op = 4'b1100;
          3'b101:  base_op = 4'b1110;
          3'b110:  base_op = 4'b1101;
          3'b111:  base_op = 4'b1111;
          default: base_op = 4'b1010;
        endcase
      2'b10:
        case (bus.FUNC3_i)
          3'b000:  base_op = (!bus.is_immediate_i && bus.FUNC7_i[5]) ? 4'b1010 : 4'b0010;
          3'b111:  base_op = 4'b0000;
          3'b110:  base_op = 4'b0001;
          3'b100:  base_op = 4'b1000;
          3'b010:  base_op = 4'b1110;
          3'b011:  base_op = 4'b1111;
          3'b001:  base_op = 4'b0100;
          default: base_op = bus.FUNC7_i[5] ? 4'b0111 : 4'b0101;
        endcase
      default: base_op = 4'b0000;
    endcase
  end
  assign accept          = bus.valid_i && !bus.stall_o && !bus.flush_i;
  assign bus.ALU_OP_o    = alu_op_q;
  assign bus.op_valid_o  = op_valid_q;
`ifdef RV_M_EXT_EN
  localparam int MAX_CYC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_mdu_q, is_mdu_d;
  logic          mdu_start_q, mdu_start_d;
  logic          m_op;
  assign m_op = bus.ALU_CO_i == 2'b10 && !bus.is_immediate_i && bus.FUNC7_i == 7'b0000001;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    op_valid_d  = 1'b0;
    is_mdu_d    = is_mdu_q;
    mdu_start_d = 1'b0;
    if (bus.flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      is_mdu_d = 1'b0;
    end else if (accept) begin
      alu_op_d    = m_op ? OP_W'({2'b10, bus.FUNC3_i}) : OP_W'(base_op);
      op_valid_d  = 1'b1;
      is_mdu_d    = m_op;
      mdu_start_d = m_op;
      if (m_op) begin
        state_d = bus.FUNC3_i[2] ? DIV_WAIT : MUL_WAIT;
        cnt_d   = bus.FUNC3_i[2] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      end
    end else if (state_q != IDLE) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == CW'(1) ? IDLE : state_q;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_op_q    <= '0;
      op_valid_q  <= 1'b0;
      is_mdu_q    <= 1'b0;
      mdu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      op_valid_q  <= op_valid_d;
      is_mdu_q    <= is_mdu_d;
      mdu_start_q <= mdu_start_d;
    end
  end
  assign bus.is_mdu_o    = is_mdu_q;
  assign bus.mdu_start_o = mdu_start_q;
  assign bus.stall_o     = state_q != IDLE;
  assign bus.done_o      = state_q != IDLE && cnt_q == CW'(1);
`else
  logic unused_func7;
  assign unused_func7 = &{1'b0, bus.FUNC7_i[6], bus.FUNC7_i[4:0]};
  always_comb begin
    alu_op_d   = accept ? OP_W'(base_op) : alu_op_q;
    op_valid_d = accept;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      alu_op_q   <= '0;
      op_valid_q <= 1'b0;
    end else begin
      alu_op_q   <= alu_op_d;
      op_valid_q <= op_valid_d;
    end
  end
  assign bus.is_mdu_o    = 1'b0;
  assign bus.mdu_start_o = 1'b0;
  assign bus.stall_o     = 1'b0;
  assign bus.done_o      = 1'b0;
`endif
endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: randomized and directed checks of alu_control_mc against a table-driven reference.
module tb_alu_control_mc;
  localparam int MULC = 2;
  localparam int DIVC = 33;
`ifdef RV_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int   checks = 0;
  int   fails = 0;
  logic [4:0] exp_op = '0;
  logic       exp_mdu = 1'b0;
  alu_control_mc_if #(.OP_W(5)) bus ();
  alu_control_mc #(.OP_W(5), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  function automatic bit is_m(logic [1:0] co, logic [6:0] f7, logic imm);
    return M_EN && co == 2'd2 && !imm && f7 == 7'd1;
  endfunction
  function automatic logic [4:0] ref_op(logic [1:0] co, logic [2:0] f3, logic [6:0] f7, logic imm);
    if (is_m(co, f7, imm)) return {2'b10, f3};
    if (co == 2'd0) return 5'd2;
    if (co == 2'd3) return 5'd0;
    if (co == 2'd1) begin
      case (f3)
        3'd1: return 5'd3;
        3'd4: return 5'd12;
        3'd5: return 5'd14;
        3'd6: return 5'd13;
        3'd7: return 5'd15;
        default: return 5'd10;
      endcase
    end
    case (f3)
      3'd0: return (!imm && f7[5]) ? 5'd10 : 5'd2;
      3'd1: return 5'd4;
      3'd2: return 5'd14;
      3'd3: return 5'd15;
      3'd4: return 5'd8;
      3'd5: return f7[5] ? 5'd7 : 5'd5;
      3'd6: return 5'd1;
      default: return 5'd0;
    endcase
  endfunction
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(logic v, logic [1:0] co, logic [2:0] f3, logic [6:0] f7, logic imm);
    bus.valid_i = v;
    bus.ALU_CO_i = co;
    bus.FUNC3_i = f3;
    bus.FUNC7_i = f7;
    bus.is_immediate_i = imm;
  endtask
  task automatic test_reset();
    bus.flush_i = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 7'd0, 1'b0);
    #12;
    checks++;
    if ({bus.ALU_OP_o, bus.op_valid_o, bus.is_mdu_o, bus.mdu_start_o, bus.stall_o, bus.done_o} !== 10'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0", {bus.ALU_OP_o, bus.op_valid_o, bus.is_mdu_o, bus.mdu_start_o, bus.stall_o, bus.done_o});
    end
    tick();
    rst_n_i = 1'b1;
    tick();
    checks++;
    if ({bus.op_valid_o, bus.stall_o, bus.ALU_OP_o} !== 7'd0) begin
      fails++;
      $display("FAIL idle_after_reset: got %b want 0", {bus.op_valid_o, bus.stall_o, bus.ALU_OP_o});
    end
  endtask
  task automatic test_base_decode();
    logic [1:0] co[6]  = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0};
    logic [2:0] f3[6]  = '{3'd0, 3'd0, 3'd5, 3'd6, 3'd0, 3'd3};
    logic [6:0] f7[6]  = '{7'h20, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00};
    logic       imm[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] want[6] = '{5'b01010, 5'b00010, 5'b00111, 5'b01101, 5'b00000, 5'b00010};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, co[i], f3[i], f7[i], imm[i]);
      tick();
      checks++;
      if ({bus.ALU_OP_o, bus.op_valid_o, bus.stall_o} !== {want[i], 2'b10}) begin
        fails++;
        $display("FAIL base_decode[%0d]: got op=%b v=%b s=%b want op=%b v=1 s=0", i, bus.ALU_OP_o, bus.op_valid_o, bus.stall_o, want[i]);
      end
    end
    drive(1'b0, 2'd1, 3'd4, 7'd0, 1'b0);
    tick();
    checks++;
    if ({bus.ALU_OP_o, bus.op_valid_o} !== {5'b00010, 1'b0}) begin
      fails++;
      $display("FAIL base_hold: got op=%b v=%b want op=00010 v=0", bus.ALU_OP_o, bus.op_valid_o);
    end
    exp_op = 5'b00010;
    exp_mdu = 1'b0;
  endtask
  task automatic test_random_ops();
    for (int n = 0; n < 60; n++) begin
      logic [1:0] co = 2'($urandom_range(0, 3));
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic [6:0] f7 = 7'($urandom);
      logic       imm = 1'($urandom);
      bit         m;
      int         len, cnt, dones, done_at;
      if ($urandom_range(0, 2) == 0) begin
        co = 2'd2;
        f7 = 7'd1;
        imm = 1'b0;
      end
      m = is_m(co, f7, imm);
      len = f3[2] ? DIVC : MULC;
      exp_op = ref_op(co, f3, f7, imm);
      exp_mdu = m;
      drive(1'b1, co, f3, f7, imm);
      tick();
      checks++;
      if ({bus.ALU_OP_o, bus.op_valid_o, bus.is_mdu_o, bus.mdu_start_o, bus.stall_o} !== {exp_op, 1'b1, m, m, m}) begin
        fails++;
        $display("FAIL rand_accept[%0d]: got op=%b v=%b mdu=%b st=%b stall=%b want op=%b v=1 mdu=%b st=%b stall=%b",
                 n, bus.ALU_OP_o, bus.op_valid_o, bus.is_mdu_o, bus.mdu_start_o, bus.stall_o, exp_op, m, m, m);
      end
      if (m) begin
        cnt = 0;
        dones = 0;
        done_at = 0;
        while (bus.stall_o && cnt < 100) begin
          cnt++;
          if (bus.done_o) begin
            dones++;
            done_at = cnt;
          end
          if (cnt > 1) begin
            checks++;
            if ({bus.op_valid_o, bus.mdu_start_o, bus.ALU_OP_o} !== {2'b00, exp_op}) begin
              fails++;
              $display("FAIL rand_stall_quiet[%0d]: got v=%b st=%b op=%b want 0 0 %b", n, bus.op_valid_o, bus.mdu_start_o, bus.ALU_OP_o, exp_op);
            end
          end
          drive(1'($urandom), 2'($urandom), 3'($urandom), 7'($urandom), 1'($urandom));
          tick();
        end
        checks++;
        if (cnt !== len || dones !== 1 || done_at !== len || bus.done_o !== 1'b0) begin
          fails++;
          $display("FAIL rand_stall_len[%0d]: got stall=%0d dones=%0d done_at=%0d want %0d 1 %0d", n, cnt, dones, done_at, len, len);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 2'($urandom), 3'($urandom), 7'($urandom), 1'($urandom));
        tick();
        checks++;
        if ({bus.op_valid_o, bus.ALU_OP_o, bus.is_mdu_o, bus.stall_o} !== {1'b0, exp_op, exp_mdu, 1'b0}) begin
          fails++;
          $display("FAIL rand_idle[%0d]: got v=%b op=%b mdu=%b want 0 %b %b", n, bus.op_valid_o, bus.ALU_OP_o, bus.is_mdu_o, exp_op, exp_mdu);
        end
      end
    end
    drive(1'b0, 2'd0, 3'd0, 7'd0, 1'b0);
    tick();
  endtask
  task automatic test_back_to_back();
    if (M_EN) begin
      drive(1'b1, 2'd2, 3'd0, 7'd1, 1'b0);
      tick();
      checks++;
      if ({bus.ALU_OP_o, bus.mdu_start_o, bus.stall_o, bus.done_o} !== {5'b10000, 3'b110}) begin
        fails++;
        $display("FAIL mul_c1: got op=%b st=%b stall=%b done=%b want 10000 1 1 0", bus.ALU_OP_o, bus.mdu_start_o, bus.stall_o, bus.done_o);
      end
      drive(1'b1, 2'd0, 3'd0, 7'd0, 1'b0);
      tick();
      checks++;
      if ({bus.stall_o, bus.done_o, bus.op_valid_o} !== 3'b110) begin
        fails++;
        $display("FAIL mul_c2: got stall=%b done=%b v=%b want 1 1 0", bus.stall_o, bus.done_o, bus.op_valid_o);
      end
      tick();
      checks++;
      if ({bus.stall_o, bus.done_o, bus.op_valid_o} !== 3'b000) begin
        fails++;
        $display("FAIL mul_c3: got stall=%b done=%b v=%b want 0 0 0", bus.stall_o, bus.done_o, bus.op_valid_o);
      end
      tick();
      checks++;
      if ({bus.op_valid_o, bus.ALU_OP_o, bus.is_mdu_o} !== {1'b1, 5'b00010, 1'b0}) begin
        fails++;
        $display("FAIL mul_held_req: got v=%b op=%b mdu=%b want 1 00010 0", bus.op_valid_o, bus.ALU_OP_o, bus.is_mdu_o);
      end
      drive(1'b0, 2'd0, 3'd0, 7'd0, 1'b0);
      tick();
    end
  endtask
  task automatic test_flush();
    if (M_EN) begin
      drive(1'b1, 2'd2, 3'd6, 7'd1, 1'b0);
      tick();
      drive(1'b0, 2'd0, 3'd0, 7'd0, 1'b0);
      repeat (4) tick();
      checks++;
      if ({bus.stall_o, bus.done_o, bus.ALU_OP_o} !== {2'b10, 5'b10110}) begin
        fails++;
        $display("FAIL rem_cycle5: got stall=%b done=%b op=%b want 1 0 10110", bus.stall_o, bus.done_o, bus.ALU_OP_o);
      end
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      checks++;
      if ({bus.stall_o, bus.done_o, bus.is_mdu_o, bus.ALU_OP_o} !== {3'b000, 5'b10110}) begin
        fails++;
        $display("FAIL rem_flush: got stall=%b done=%b mdu=%b op=%b want 0 0 0 10110", bus.stall_o, bus.done_o, bus.is_mdu_o, bus.ALU_OP_o);
      end
      tick();
      checks++;
      if ({bus.stall_o, bus.done_o} !== 2'b00) begin
        fails++;
        $display("FAIL rem_no_done: got stall=%b done=%b want 0 0", bus.stall_o, bus.done_o);
      end
    end
    drive(1'b1, 2'd2, 3'd0, 7'd0, 1'b0);
    tick();
    drive(1'b1, 2'd1, 3'd4, 7'd0, 1'b0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 7'd0, 1'b0);
    checks++;
    if ({bus.op_valid_o, bus.ALU_OP_o} !== {1'b0, 5'b00010}) begin
      fails++;
      $display("FAIL flush_beats_valid: got v=%b op=%b want 0 00010", bus.op_valid_o, bus.ALU_OP_o);
    end
  endtask
  task automatic test_async_reset();
    if (M_EN) begin
      drive(1'b1, 2'd2, 3'd5, 7'd1, 1'b0);
      tick();
      drive(1'b0, 2'd0, 3'd0, 7'd0, 1'b0);
      repeat (3) tick();
      #2 rst_n_i = 1'b0;
      #1;
      checks++;
      if ({bus.ALU_OP_o, bus.op_valid_o, bus.is_mdu_o, bus.mdu_start_o, bus.stall_o, bus.done_o} !== 10'd0) begin
        fails++;
        $display("FAIL async_reset: got %b want 0", {bus.ALU_OP_o, bus.op_valid_o, bus.is_mdu_o, bus.mdu_start_o, bus.stall_o, bus.done_o});
      end
      tick();
      rst_n_i = 1'b1;
    end else begin
      drive(1'b1, 2'd2, 3'd0, 7'd1, 1'b0);
      tick();
      drive(1'b0, 2'd0, 3'd0, 7'd0, 1'b0);
      checks++;
      if ({bus.ALU_OP_o, bus.op_valid_o, bus.stall_o, bus.is_mdu_o, bus.mdu_start_o} !== {5'b00010, 4'b1000}) begin
        fails++;
        $display("FAIL no_m_decode: got op=%b v=%b stall=%b mdu=%b st=%b want 00010 1 0 0 0", bus.ALU_OP_o, bus.op_valid_o, bus.stall_o, bus.is_mdu_o, bus.mdu_start_o);
      end
      tick();
      checks++;
      if ({bus.stall_o, bus.done_o} !== 2'b00) begin
        fails++;
        $display("FAIL no_m_stall: got stall=%b done=%b want 0 0", bus.stall_o, bus.done_o);
      end
    end
  endtask
  initial begin
    test_reset();
    test_base_decode();
    test_random_ops();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
